// File: rtl/prog_loader.sv
// Byte-stream loader for the 128x16 instruction memory; holds the CPU in reset until the image is in.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic [ADDR_W-1:0] IM_W_Addr,
    output logic [15:0]       IM_W_Data,
    output logic              IM_W_en,
    output logic              CPU_Hold,
    output logic              Done,
    output logic              Error,
    output logic [7:0]        Word_Count
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_DONE, S_ERR, S_CHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t              state_q, state_d;
    logic [7:0]          n_q, n_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic [7:0]          count_q, count_d;
    logic                xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            hi_q      <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            count_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    always_comb begin
        Byte_Ready = 1'b0;
        case (state_q)
            S_COUNT, S_HI, S_LO: Byte_Ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK:             Byte_Ready = 1'b1;
`endif
            default:             Byte_Ready = 1'b0;
        endcase
    end

    assign xfer       = Byte_Valid && Byte_Ready;
    assign IM_W_en    = (state_q == S_WRITE);
    assign Done       = (state_q == S_DONE);
    assign Error      = (state_q == S_ERR);
    assign CPU_Hold   = (state_q != S_DONE);
    assign IM_W_Addr  = wr_addr_q;
    assign IM_W_Data  = wr_data_q;
    assign Word_Count = count_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        count_d   = count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d = S_COUNT;
                    addr_d  = '0;
                    count_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    n_d = Byte_In;
                    if (Byte_In == 8'd0 || {1'b0, Byte_In} > DEPTH_W) state_d = S_ERR;
                    else                                              state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = Byte_In;
                    state_d = S_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ Byte_In;
`endif
                end
            end
            S_LO: begin
                // Output registers load only here so they hold steady between writes.
                if (xfer) begin
                    wr_data_d = {hi_q, Byte_In};
                    wr_addr_d = addr_q;
                    state_d   = S_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d     = xor_q ^ Byte_In;
`endif
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + 8'd1;
                if (count_q + 8'd1 == n_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) state_d = (Byte_In == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule
